// File: rtl/gen_scan_ctrl.sv
// Scan sequencer for a generate-loop array of single-bit leaves: writes a latched
// pattern through the shared port, reads every leaf back and reports mismatches.
module gen_scan_ctrl #(
    parameter int LENGTH = 4,
    parameter int RD_LAT = 1,
    localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LENGTH-1:0] pattern,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  leaf_sel,
    output logic              leaf_we,
    output logic              leaf_wdata,
    input  logic              leaf_rdata,
    output logic [IDX_W:0]    err_count,
    output logic [IDX_W-1:0]  first_err_idx
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(LENGTH - 1);
    localparam logic [1:0]       LAT  = 2'(RD_LAT);

    state_t            state;
    logic [LENGTH-1:0] pattern_q;
    logic [1:0]        wcnt;
    logic [IDX_W-1:0]  idx_nxt;
    logic              miss;

    // leaf_sel doubles as the scan index; it is 0 whenever the port is idle
    assign idx_nxt = leaf_sel + 1'b1;
    assign miss    = leaf_rdata != pattern_q[leaf_sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pattern_q     <= '0;
            wcnt          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            leaf_sel      <= '0;
            leaf_we       <= 1'b0;
            leaf_wdata    <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pattern_q     <= pattern;
                        err_count     <= '0;
                        first_err_idx <= '0;
                        leaf_sel      <= '0;
                        busy          <= 1'b1;
                        leaf_we       <= 1'b1;
                        leaf_wdata    <= pattern[0];
                        state         <= WRITE;
                    end
                end
                WRITE: begin
                    if (leaf_sel == LAST) begin
                        leaf_sel   <= '0;
                        wcnt       <= '0;
                        leaf_we    <= 1'b0;
                        leaf_wdata <= 1'b0;
                        state      <= READ;
                    end else begin
                        leaf_sel   <= idx_nxt;
                        leaf_wdata <= pattern_q[idx_nxt];
                    end
                end
                READ: begin
                    // rdata is trusted only once the select has been stable RD_LAT cycles
                    if (wcnt == LAT) begin
                        wcnt <= '0;
                        if (miss) begin
                            err_count <= err_count + 1'b1;
                            if (err_count == '0)
                                first_err_idx <= leaf_sel;
                        end
                        if (leaf_sel == LAST) begin
                            leaf_sel <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            leaf_sel <= idx_nxt;
                        end
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gen_scan_ctrl.sv
// Directed bench for gen_scan_ctrl: three instances (4/1, 8/2, 1/0) with
// behavioural leaf arrays, a vector table of scans, and hand-written corner cases.
module tb_gen_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [7:0] pat = '0;
    logic [7:0] stuck = '0;
    int dsel = 0;

    always #5 clk = ~clk;

    // instance 0: LENGTH=4 RD_LAT=1
    logic busy4, done4, we4, wd4, rd4;
    logic [1:0] sel4, first4;
    logic [2:0] err4;
    logic [3:0] lf4 = '0;
    gen_scan_ctrl #(.LENGTH(4), .RD_LAT(1)) u4 (
        .clk(clk), .rst(rst), .start(start && dsel == 0), .pattern(pat[3:0]),
        .busy(busy4), .done(done4), .leaf_sel(sel4), .leaf_we(we4), .leaf_wdata(wd4),
        .leaf_rdata(rd4), .err_count(err4), .first_err_idx(first4));
    always @(posedge clk) begin
        if (we4) lf4[sel4] <= wd4 & ~stuck[sel4];
        rd4 <= lf4[sel4];
    end

    // instance 1: LENGTH=8 RD_LAT=2
    logic busy8, done8, we8, wd8, rd8, rd8a;
    logic [2:0] sel8, first8;
    logic [3:0] err8;
    logic [7:0] lf8 = '0;
    gen_scan_ctrl #(.LENGTH(8), .RD_LAT(2)) u8 (
        .clk(clk), .rst(rst), .start(start && dsel == 1), .pattern(pat),
        .busy(busy8), .done(done8), .leaf_sel(sel8), .leaf_we(we8), .leaf_wdata(wd8),
        .leaf_rdata(rd8), .err_count(err8), .first_err_idx(first8));
    always @(posedge clk) begin
        if (we8) lf8[sel8] <= wd8 & ~stuck[sel8];
        rd8a <= lf8[sel8];
        rd8  <= rd8a;
    end

    // instance 2: LENGTH=1 RD_LAT=0 (combinational read)
    logic busy1, done1, we1, wd1, sel1, first1;
    logic [1:0] err1;
    logic lf1 = 1'b0;
    gen_scan_ctrl #(.LENGTH(1), .RD_LAT(0)) u1 (
        .clk(clk), .rst(rst), .start(start && dsel == 2), .pattern(pat[0]),
        .busy(busy1), .done(done1), .leaf_sel(sel1), .leaf_we(we1), .leaf_wdata(wd1),
        .leaf_rdata(lf1), .err_count(err1), .first_err_idx(first1));
    always @(posedge clk) begin
        if (we1) lf1 <= wd1 & ~stuck[0];
    end

    int busy_m, done_m, we_m, wd_m, sel_m, err_m, first_m;
    always_comb begin
        busy_m = 0; done_m = 0; we_m = 0; wd_m = 0; sel_m = 0; err_m = 0; first_m = 0;
        case (dsel)
            0: begin busy_m = busy4; done_m = done4; we_m = we4; wd_m = wd4;
                     sel_m = sel4; err_m = err4; first_m = first4; end
            1: begin busy_m = busy8; done_m = done8; we_m = we8; wd_m = wd8;
                     sel_m = sel8; err_m = err8; first_m = first8; end
            default: begin busy_m = busy1; done_m = done1; we_m = we1; wd_m = wd1;
                     sel_m = sel1; err_m = err1; first_m = first1; end
        endcase
    end

    int n_chk = 0;
    int n_pass = 0;
    int we_log[256];
    int wd_log[256];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, busy_m, 0);
        chk({tag, "_done"}, done_m, 0);
        chk({tag, "_sel"}, sel_m, 0);
        chk({tag, "_we"}, we_m, 0);
        chk({tag, "_wdata"}, wd_m, 0);
        chk({tag, "_err"}, err_m, 0);
        chk({tag, "_first"}, first_m, 0);
    endtask

    // start sampled on edge 0; cycle n is the interval after edge n-1
    task automatic run_scan(input int d, input logic [7:0] p, input logic [7:0] s,
                            input int e_err, input int e_first, input int e_done);
        int cyc;
        bit got, busy_ok;
        dsel = d;
        stuck = s;
        @(negedge clk);
        pat = p;
        start = 1'b1;
        @(posedge clk);
        cyc = 0; got = 0; busy_ok = 1;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            we_log[cyc] = we_m;
            wd_log[cyc] = wd_m;
            if (done_m != 0) got = 1;
            else if (busy_m == 0) busy_ok = 0;
        end
        chk("done_cycle", got ? cyc : -1, e_done);
        chk("err_count", err_m, e_err);
        chk("first_err_idx", first_m, e_first);
        chk("busy_during_scan", busy_ok, 1);
        @(negedge clk);
        chk("done_one_cycle", done_m, 0);
        chk("err_held_after_done", err_m, e_err);
    endtask

    typedef struct {
        int d;
        logic [7:0] p;
        logic [7:0] s;
        int e_err;
        int e_first;
        int e_done;
    } vec_t;

    vec_t vecs[8];
    logic [3:0] exp_wd;

    initial begin
        vecs[0] = '{0, 8'h0A, 8'h00, 0, 0, 13};
        vecs[1] = '{0, 8'h0F, 8'h04, 1, 2, 13};
        vecs[2] = '{1, 8'hFF, 8'h4A, 3, 1, 33};
        vecs[3] = '{2, 8'h01, 8'h00, 0, 0, 3};
        vecs[4] = '{2, 8'h01, 8'h01, 1, 0, 3};
        vecs[5] = '{0, 8'h05, 8'h0F, 2, 0, 13};
        vecs[6] = '{1, 8'h80, 8'h80, 1, 7, 33};
        vecs[7] = '{1, 8'h00, 8'h00, 0, 0, 33};

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            dsel = d;
            #0;
            chk_idle_zero("reset");
        end
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_scan(vecs[i].d, vecs[i].p, vecs[i].s, vecs[i].e_err, vecs[i].e_first, vecs[i].e_done);
            if (i == 0) begin
                exp_wd = 4'b1010;
                for (int c = 1; c <= 4; c++) begin
                    chk("write_we", we_log[c], 1);
                    chk("write_wdata", wd_log[c], int'(exp_wd[c-1]));
                end
                chk("read_we_low", we_log[5], 0);
            end
            if (i == 3) begin
                chk("len1_write_c1", we_log[1], 1);
                chk("len1_wdata_c1", wd_log[1], 1);
                chk("len1_read_c2", we_log[2], 0);
            end
        end

        // start held high; pattern changes mid-scan and must not affect scan 1
        dsel = 0;
        stuck = '0;
        @(negedge clk);
        pat = 8'h0F;
        start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(negedge clk);
            if (cyc == 3) pat = 8'h05;
            if (cyc == 13) begin
                chk("held_done1", done_m, 1);
                chk("held_err1", err_m, 0);
                stuck = 8'h01;
            end
            if (cyc == 14) chk("held_idle_busy", busy_m, 0);
            if (cyc == 15) begin
                chk("held_scan2_we", we_m, 1);
                chk("held_scan2_wdata0", wd_m, 1);
            end
            if (cyc == 16) chk("held_scan2_wdata1", wd_m, 0);
            if (cyc == 27) begin
                chk("held_done2", done_m, 1);
                chk("held_err2", err_m, 1);
                chk("held_first2", first_m, 0);
            end
            if (cyc == 40) start = 1'b0;
            if (cyc == 41) chk("held_done3", done_m, 1);
        end

        // reset in cycle 7 after one error has already been counted
        stuck = 8'h01;
        @(negedge clk);
        pat = 8'h0F;
        start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 7) begin
                chk("pre_reset_err", err_m, 1);
                rst = 1'b1;
            end
            if (cyc == 8) begin
                chk_idle_zero("mid_reset");
                rst = 1'b0;
            end
        end
        run_scan(0, 8'h0A, 8'h00, 0, 0, 13);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
